// File: rtl/uart_cfg_sched_if.sv
// Command, TX FIFO and status-response signals shared by the scheduler and its neighbours.
// master is the scheduler side; slave is the SPI controller / FIFO side.
interface uart_cfg_sched_if;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] tx_fifo_data;
    logic        tx_fifo_en;
    logic        tx_fifo_full;
    logic        tx_fifo_empty;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;

    modport master (
        input  cmd_data, cmd_valid, tx_fifo_full, tx_fifo_empty, rsp_ready,
        output cmd_ready, tx_fifo_data, tx_fifo_en, rsp_data, rsp_valid
    );

    modport slave (
        output cmd_data, cmd_valid, tx_fifo_full, tx_fifo_empty, rsp_ready,
        input  cmd_ready, tx_fifo_data, tx_fifo_en, rsp_data, rsp_valid
    );
endinterface

// File: rtl/uart_cfg_sched.sv
// Command scheduler between the SPI controller and the UART TX path.
// Baud divisor changes are deferred until the TX FIFO and shifter are both idle.
module uart_cfg_sched #(
    parameter logic [15:0] BAUD_DEFAULT  = 16'd434,
    parameter logic [15:0] BAUD_MIN      = 16'd16,
    parameter logic [15:0] DRAIN_TIMEOUT = 16'd4096
) (
    input  logic             clk,
    input  logic             rst,
    uart_cfg_sched_if.master bus,
    input  logic             uart_busy_i,
    input  logic             rx_fifo_empty_i,
    output logic [15:0]      baud_o,
    output logic [3:0]       state_o,
    output logic             err_o
);
    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StDataWait = 4'd1,
        StDrain    = 4'd2,
        StApply    = 4'd3,
        StRsp      = 4'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        tx_en_q, tx_en_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [1:0]  opcode;
    logic [15:0] divisor;
    logic        cmd_hs;

    assign opcode  = bus.cmd_data[15:14];
    assign divisor = {2'b00, bus.cmd_data[13:0]};
    assign cmd_hs  = bus.cmd_valid & cmd_ready_q;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_en_d    = 1'b0;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    case (opcode)
                        2'b00: begin
                            tx_data_d = {8'h00, bus.cmd_data[7:0]};
                            if (!bus.tx_fifo_full) tx_en_d = 1'b1;
                            else                   state_d = StDataWait;
                        end
                        2'b01: begin
                            if (divisor < BAUD_MIN) begin
                                err_d      = 1'b1;
                                err_code_d = 2'd1;
                            end else begin
                                pend_d  = divisor;
                                cnt_d   = 16'd0;
                                state_d = StDrain;
                            end
                        end
                        2'b10: begin
                            // Snapshot taken on entry so the word stays stable while stalled.
                            rsp_data_d = {err_q, err_code_q, bus.tx_fifo_full, bus.tx_fifo_empty,
                                          rx_fifo_empty_i, uart_busy_i, 1'b0, baud_q[7:0]};
                            state_d    = StRsp;
                        end
                        default: begin
                            err_d      = 1'b0;
                            err_code_d = 2'd0;
                        end
                    endcase
                end
            end
            StDataWait: begin
                if (!bus.tx_fifo_full) begin
                    tx_en_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.tx_fifo_empty && !uart_busy_i) begin
                    state_d = StApply;
                end else if (cnt_q == DRAIN_TIMEOUT - 16'd1) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = StIdle;
                end
            end
            StApply: begin
                baud_d  = pend_q;
                state_d = StIdle;
            end
            StRsp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            baud_q      <= BAUD_DEFAULT;
            pend_q      <= 16'd0;
            cnt_q       <= 16'd0;
            tx_data_q   <= 16'd0;
            tx_en_q     <= 1'b0;
            rsp_data_q  <= 16'd0;
            cmd_ready_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            rsp_data_q  <= rsp_data_d;
            cmd_ready_q <= cmd_ready_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.tx_fifo_data = tx_data_q;
    assign bus.tx_fifo_en   = tx_en_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_valid    = (state_q == StRsp);
    assign baud_o           = baud_q;
    assign state_o          = state_q;
    assign err_o            = err_q;
endmodule

// File: tb/tb_uart_cfg_sched.sv
// Bench for uart_cfg_sched: directed scenarios followed by random command traffic
// checked against a transaction-level model of baud, error and FIFO-write behaviour.
module tb_uart_cfg_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        uart_busy;
    logic        rx_fifo_empty;
    logic [15:0] baud;
    logic [3:0]  state;
    logic        err;

    uart_cfg_sched_if bus ();

    uart_cfg_sched dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .uart_busy_i     (uart_busy),
        .rx_fifo_empty_i (rx_fifo_empty),
        .baud_o          (baud),
        .state_o         (state),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_baud;
    logic        m_err;
    logic [1:0]  m_code;
    logic [15:0] got_q[$];
    logic [13:0] rnd_div;

    // Collect every FIFO write strobe seen by the DUT's neighbour.
    always begin
        @(posedge clk);
        #2;
        if (!rst && bus.tx_fifo_en) got_q.push_back(bus.tx_fifo_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] w);
        logic rdy;
        int   n;
        bus.cmd_data  = w;
        bus.cmd_valid = 1'b1;
        n = 0;
        do begin
            rdy = bus.cmd_ready;
            cycle();
            n++;
        end while (!rdy && n < 6000);
        bus.cmd_valid = 1'b0;
        if (!rdy) check_eq("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_data(input logic [15:0] w, input int hold);
        logic [15:0] exp;
        exp = {8'h00, w[7:0]};
        got_q.delete();
        bus.tx_fifo_full = (hold != 0);
        issue(w);
        if (hold != 0) begin
            check_eq("data_wait_state", 32'(state), 32'd1);
            check_eq("data_wait_ready", 32'(bus.cmd_ready), 32'd0);
            repeat (hold - 1) cycle();
            check_eq("data_wait_no_write", got_q.size(), 32'd0);
            bus.tx_fifo_full = 1'b0;
            cycle();
        end
        check_eq("data_en", 32'(bus.tx_fifo_en), 32'd1);
        check_eq("data_word", 32'(bus.tx_fifo_data), 32'(exp));
        check_eq("data_idle", 32'(state), 32'd0);
        cycle();
        check_eq("data_en_single", 32'(bus.tx_fifo_en), 32'd0);
        check_eq("data_write_count", got_q.size(), 32'd1);
        if (got_q.size() != 0) check_eq("data_write_val", 32'(got_q.pop_front()), 32'(exp));
    endtask

    task automatic do_setbaud(input logic [13:0] div, input int hold);
        bus.tx_fifo_empty = 1'b1;
        uart_busy         = (hold != 0);
        issue({2'b01, div});
        if (div < 14'd16) begin
            m_err     = 1'b1;
            m_code    = 2'd1;
            uart_busy = 1'b0;
            check_eq("setbaud_reject_state", 32'(state), 32'd0);
            check_eq("setbaud_reject_err", 32'(err), 32'd1);
        end else begin
            check_eq("drain_state", 32'(state), 32'd2);
            repeat (hold) cycle();
            check_eq("drain_hold_state", 32'(state), 32'd2);
            check_eq("drain_hold_baud", 32'(baud), 32'(m_baud));
            uart_busy = 1'b0;
            cycle();
            check_eq("apply_state", 32'(state), 32'd3);
            check_eq("apply_old_baud", 32'(baud), 32'(m_baud));
            cycle();
            m_baud = {2'b00, div};
            check_eq("apply_new_baud", 32'(baud), 32'(m_baud));
            check_eq("apply_idle", 32'(state), 32'd0);
        end
    endtask

    task automatic do_status(input int dly);
        logic [15:0] exp;
        bus.tx_fifo_full  = 1'($urandom);
        bus.tx_fifo_empty = 1'($urandom);
        rx_fifo_empty     = 1'($urandom);
        uart_busy         = 1'($urandom);
        bus.rsp_ready     = 1'b0;
        exp = {m_err, m_code, bus.tx_fifo_full, bus.tx_fifo_empty, rx_fifo_empty, uart_busy,
               1'b0, m_baud[7:0]};
        issue(16'h8000 | 16'($urandom_range(0, 16383)));
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp));
        check_eq("rsp_state", 32'(state), 32'd4);
        for (int i = 0; i < dly; i++) begin
            bus.tx_fifo_full  = 1'($urandom);
            bus.tx_fifo_empty = 1'($urandom);
            rx_fifo_empty     = 1'($urandom);
            uart_busy         = 1'($urandom);
            cycle();
            check_eq("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("rsp_hold_data", 32'(bus.rsp_data), 32'(exp));
        end
        bus.rsp_ready = 1'b1;
        cycle();
        bus.rsp_ready     = 1'b0;
        bus.tx_fifo_full  = 1'b0;
        bus.tx_fifo_empty = 1'b1;
        uart_busy         = 1'b0;
        check_eq("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rsp_done_state", 32'(state), 32'd0);
    endtask

    task automatic do_clrerr();
        issue(16'hC000 | 16'($urandom_range(0, 16383)));
        m_err  = 1'b0;
        m_code = 2'd0;
        check_eq("clrerr_err", 32'(err), 32'd0);
        check_eq("clrerr_state", 32'(state), 32'd0);
    endtask

    initial begin
        int n;
        rst               = 1'b1;
        uart_busy         = 1'b0;
        rx_fifo_empty     = 1'b1;
        bus.cmd_data      = 16'h0000;
        bus.cmd_valid     = 1'b0;
        bus.tx_fifo_full  = 1'b0;
        bus.tx_fifo_empty = 1'b1;
        bus.rsp_ready     = 1'b0;
        m_baud = 16'd434;
        m_err  = 1'b0;
        m_code = 2'd0;

        repeat (3) cycle();
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("rst_baud", 32'(baud), 32'd434);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_tx_en", 32'(bus.tx_fifo_en), 32'd0);
        check_eq("rst_tx_data", 32'(bus.tx_fifo_data), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        rst = 1'b0;
        cycle();
        check_eq("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        do_data(16'h00A5, 0);
        do_data(16'h3F33, 5);

        // Back-to-back DATA: one write per cycle.
        got_q.delete();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'h0011;
        cycle();
        check_eq("b2b_en0", 32'(bus.tx_fifo_en), 32'd1);
        check_eq("b2b_data0", 32'(bus.tx_fifo_data), 32'h0011);
        bus.cmd_data = 16'h1222;
        cycle();
        bus.cmd_valid = 1'b0;
        check_eq("b2b_en1", 32'(bus.tx_fifo_en), 32'd1);
        check_eq("b2b_data1", 32'(bus.tx_fifo_data), 32'h0022);
        cycle();
        check_eq("b2b_count", got_q.size(), 32'd2);

        do_setbaud(14'd54, 20);
        do_setbaud(14'd8, 0);
        do_status(3);
        do_clrerr();

        // Drain never completes: timeout after exactly DRAIN_TIMEOUT cycles.
        uart_busy = 1'b1;
        issue(16'h4100);
        n = 0;
        while (state != 4'd0 && n < 5000) begin
            cycle();
            n++;
        end
        check_eq("timeout_cycles", n, 32'd4096);
        uart_busy = 1'b0;
        m_err  = 1'b1;
        m_code = 2'd2;
        check_eq("timeout_err", 32'(err), 32'd1);
        check_eq("timeout_baud", 32'(baud), 32'(m_baud));
        do_status(0);
        do_clrerr();

        // Drain completes on the very last cycle before timeout: drain wins.
        uart_busy = 1'b1;
        issue(16'h4123);
        repeat (4095) cycle();
        uart_busy = 1'b0;
        cycle();
        check_eq("tie_apply_state", 32'(state), 32'd3);
        check_eq("tie_err", 32'(err), 32'd0);
        cycle();
        m_baud = 16'h0123;
        check_eq("tie_baud", 32'(baud), 32'(m_baud));

        // Reset in the middle of a drain discards the pending divisor.
        uart_busy = 1'b1;
        issue(16'h4050);
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst       = 1'b0;
        uart_busy = 1'b0;
        m_baud = 16'd434;
        m_err  = 1'b0;
        m_code = 2'd0;
        repeat (4) cycle();
        check_eq("rst_mid_state", 32'(state), 32'd0);
        check_eq("rst_mid_baud", 32'(baud), 32'(m_baud));
        check_eq("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);

        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 3))
                0: do_data(16'($urandom) & 16'h3FFF, int'($urandom_range(0, 3)));
                1: begin
                    if ($urandom_range(0, 2) == 0) rnd_div = 14'($urandom_range(0, 15));
                    else                           rnd_div = 14'($urandom_range(16, 16383));
                    do_setbaud(rnd_div, int'($urandom_range(0, 6)));
                end
                2: do_status(int'($urandom_range(0, 3)));
                default: do_clrerr();
            endcase
            check_eq("rnd_baud", 32'(baud), 32'(m_baud));
            check_eq("rnd_err", 32'(err), 32'(m_err));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_cfg_sched.md
Name: uart_cfg_sched

Overview:
- Command scheduler between the SPI controller and the UART/FIFO datapath.
- Accepts 16-bit command words, forwards data words into the TX FIFO, and answers status reads through a response port.
- Applies baud-divisor changes only after the TX path has fully drained, so no in-flight byte is sent at a mixed rate.
- Drives the `baud` divisor and the 4-bit `state` code consumed by the UART and SPI controllers.

Parameters:
- BAUD_DEFAULT, 16'd434, divisor loaded at reset (50 MHz / 115200).
- BAUD_MIN, 16'd16, smallest legal divisor; smaller requests are rejected.
- DRAIN_TIMEOUT, 16'd4096, max cycles spent waiting for drain before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_data  in  16  command word
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- tx_fifo_data  out  16  word written to TX FIFO
- tx_fifo_en  out  1  TX FIFO write strobe, single cycle
- tx_fifo_full  in  1  TX FIFO full
- tx_fifo_empty  in  1  TX FIFO empty
- uart_busy  in  1  UART transmitter shifting a frame
- rx_fifo_empty  in  1  RX FIFO empty (status only)
- rsp_data  out  16  status response word
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- baud  out  16  active baud divisor
- state  out  4  FSM state code
- err  out  1  sticky error flag

Behaviour:
- Reset values:
  - baud=BAUD_DEFAULT, state=IDLE(4'd0), err=0, err_code=0.
  - cmd_ready=0, tx_fifo_en=0, tx_fifo_data=0, rsp_valid=0, rsp_data=0.
  - Timeout counter=0, pending divisor=0.
- Reset mid-operation aborts any drain or response and discards the pending divisor.
- Opcode is cmd_data[15:14]:
  - 00 DATA: payload = {8'h00, cmd_data[7:0]}.
  - 01 SETBAUD: divisor = {2'b00, cmd_data[13:0]}.
  - 10 STATUS: read request.
  - 11 CLRERR: clears err.
- IDLE(0): cmd_ready=1. On handshake, dispatch by opcode.
  - DATA: if !tx_fifo_full, tx_fifo_en=1 next cycle with the payload; stay IDLE. If full, go to DATA_WAIT.
  - SETBAUD: if divisor<BAUD_MIN, set err=1, err_code=1, stay IDLE, baud unchanged. Otherwise latch the divisor, go to DRAIN, clear the counter.
  - STATUS: go to RSP.
  - CLRERR: err=0, err_code=0, stay IDLE.
- DATA_WAIT(1): cmd_ready=0, payload held. When !tx_fifo_full, pulse tx_fifo_en for one cycle, then return to IDLE.
- DRAIN(2): cmd_ready=0, counter increments each cycle.
  - If tx_fifo_empty & !uart_busy in the same cycle, go to APPLY.
  - Else if counter==DRAIN_TIMEOUT-1, set err=1, err_code=2, return to IDLE, baud unchanged.
  - Drain detection takes precedence over timeout in the same cycle.
- APPLY(3): baud <= pending divisor. Exactly one cycle, then IDLE. baud never changes in any other state.
- RSP(4): rsp_valid=1 and rsp_data = {err, err_code[1:0], tx_fifo_full, tx_fifo_empty, rx_fifo_empty, uart_busy, 1'b0, baud[7:0]}.
  - Sampled on RSP entry and held stable while rsp_valid & !rsp_ready.
  - On rsp_ready, rsp_valid drops and FSM returns to IDLE.
- state output equals the FSM code; undefined codes recover to IDLE.
- Throughput: back-to-back DATA commands with FIFO not full give one tx_fifo_en per cycle, latency 1 cycle from handshake.
- tx_fifo_en is never asserted while tx_fifo_full is sampled high.
- err is sticky; only CLRERR or rst clears it. A new error overwrites err_code.

Test Plan:
- Reset -> baud=434, state=0, err=0, cmd_ready=1 the cycle after rst deasserts.
- DATA 16'h00A5 with FIFO not full -> tx_fifo_en high exactly 1 cycle, tx_fifo_data=16'h00A5.
- DATA with tx_fifo_full=1 for 5 cycles -> state=1, no tx_fifo_en, cmd_ready=0. The write fires 1 cycle after full drops.
- SETBAUD 16'h4036 (divisor 54) with uart_busy high 20 cycles -> baud stays 434 until drain, then becomes 54 via state 3. SETBAUD divisor 8 -> err=1, baud unchanged.
- SETBAUD with uart_busy stuck high -> after 4096 cycles err=1, err_code=2, state=0, baud unchanged. CLRERR -> err=0.
- STATUS with rsp_ready low 3 cycles -> rsp_valid held, rsp_data stable. rsp_ready=1 -> rsp_valid=0, state=0.
